// File: rtl/save_state_pkg.sv
// ---------------------------------------------------------------------------
// save_state_pkg
// Shared definitions for the context saver and its resume-loader counterpart:
// RAM direction codes, frame word indices, the call-stack-pointer bias, the
// bit positions of each field inside the two frame words, the saver state
// encoding and the frame packing helpers.
// ---------------------------------------------------------------------------
package save_state_pkg;

    // RAM geometry; the frame packing only works for an 8-bit address/SP
    // and a 16-bit data word.
    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 16;
    localparam int PC_BITS   = 9;
    localparam int FLAG_BITS = 4;

    // RAM direction codes
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    // Word offsets inside the frame, relative to the frame base address
    localparam int FRAME_WORD_POINTERS = 0;
    localparam int FRAME_WORD_PC_FLAGS = 1;

    // The loader adds this back to the stored CSP; the saver subtracts it.
    localparam logic [ADDR_BITS-1:0] CSP_FRAME_BIAS = 8'd2;

    // Field positions in word 0
    localparam int SP_MSB  = 15;
    localparam int SP_LSB  = 8;
    localparam int CSP_MSB = 7;
    localparam int CSP_LSB = 0;

    // Field positions in word 1 (bits 11:9 are always zero)
    localparam int FLAGS_MSB = 15;
    localparam int FLAGS_LSB = 12;
    localparam int PC_MSB    = 8;
    localparam int PC_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE_SP = 2'd1,
        ST_WRITE_PC = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Word 0: {sp, biased csp}
    function automatic logic [DATA_BITS-1:0] pack_pointers(
        input logic [ADDR_BITS-1:0] sp,
        input logic [ADDR_BITS-1:0] csp_biased
    );
        logic [DATA_BITS-1:0] word;
        word                   = 16'h0000;
        word[SP_MSB:SP_LSB]    = sp;
        word[CSP_MSB:CSP_LSB]  = csp_biased;
        return word;
    endfunction

    // Word 1: {flags, 3'b000, pc}
    function automatic logic [DATA_BITS-1:0] pack_pc_flags(
        input logic [PC_BITS-1:0]   pc,
        input logic [FLAG_BITS-1:0] flags
    );
        logic [DATA_BITS-1:0] word;
        word                      = 16'h0000;
        word[FLAGS_MSB:FLAGS_LSB] = flags;
        word[PC_MSB:PC_LSB]       = pc;
        return word;
    endfunction

endpackage

// File: rtl/save_state_if.sv
// ---------------------------------------------------------------------------
// save_state_if
// Bundles the save request, the live context inputs and the RAM-side/status
// outputs of save_state.
//   i_start                 : single-cycle save request
//   i_stack_pointer         : live data-stack pointer
//   i_call_stack_pointer    : live call-stack pointer
//   i_program_counter       : live program counter
//   i_alu_flags             : live ALU flags
//   o_address / o_data_in   : RAM address and write data
//   o_rw_mode               : RAM_WRITE during write states, else RAM_READ
//   o_busy / o_finished     : save in progress / save complete
// master = requester (scheduler), slave = save_state.
// ---------------------------------------------------------------------------
interface save_state_if;
    import save_state_pkg::*;

    logic                   i_start;
    logic [ADDR_BITS-1:0]   i_stack_pointer;
    logic [ADDR_BITS-1:0]   i_call_stack_pointer;
    logic [PC_BITS-1:0]     i_program_counter;
    logic [FLAG_BITS-1:0]   i_alu_flags;
    logic [ADDR_BITS-1:0]   o_address;
    logic [DATA_BITS-1:0]   o_data_in;
    logic                   o_rw_mode;
    logic                   o_busy;
    logic                   o_finished;

    modport master (
        output i_start, i_stack_pointer, i_call_stack_pointer,
               i_program_counter, i_alu_flags,
        input  o_address, o_data_in, o_rw_mode, o_busy, o_finished
    );

    modport slave (
        input  i_start, i_stack_pointer, i_call_stack_pointer,
               i_program_counter, i_alu_flags,
        output o_address, o_data_in, o_rw_mode, o_busy, o_finished
    );

endinterface

// File: rtl/save_state.sv
// ---------------------------------------------------------------------------
// save_state
// On a start request, snapshots SP, CSP, PC and ALU flags and writes them as
// a two-word frame to RAM at FRAME_BASE / FRAME_BASE+1, two cycles per word.
// The frame is the exact inverse of what the resume loader reads back.
// Ports:
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : save_state_if.slave (request, context, RAM and status signals)
// Parameter:
//   FRAME_BASE : RAM address of frame word 0 (word 1 wraps modulo 2^8)
// ---------------------------------------------------------------------------
module save_state
    import save_state_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] FRAME_BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    save_state_if.slave bus
);

    localparam logic [ADDR_BITS-1:0] ADDR_W0 =
        FRAME_BASE + ADDR_BITS'(FRAME_WORD_POINTERS);
    localparam logic [ADDR_BITS-1:0] ADDR_W1 =
        FRAME_BASE + ADDR_BITS'(FRAME_WORD_PC_FLAGS);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_ram_cycle;
    logic                   w_ram_cycle_next;
    logic                   w_accept;

    logic [ADDR_BITS-1:0]   r_sp_snap;
    logic [ADDR_BITS-1:0]   r_csp_snap;
    logic [PC_BITS-1:0]     r_pc_snap;
    logic [FLAG_BITS-1:0]   r_flag_snap;
    logic [ADDR_BITS-1:0]   w_sp_snap_next;
    logic [ADDR_BITS-1:0]   w_csp_snap_next;
    logic [PC_BITS-1:0]     w_pc_snap_next;
    logic [FLAG_BITS-1:0]   w_flag_snap_next;

    logic [ADDR_BITS-1:0]   r_address;
    logic [DATA_BITS-1:0]   r_data_in;
    logic                   r_rw_mode;
    logic                   r_busy;
    logic                   r_finished;
    logic [ADDR_BITS-1:0]   w_address_next;
    logic [DATA_BITS-1:0]   w_data_in_next;
    logic                   w_rw_mode_next;
    logic                   w_busy_next;
    logic                   w_finished_next;

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_next     = r_state;
        w_ram_cycle_next = r_ram_cycle;
        w_accept         = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    w_state_next     = ST_WRITE_SP;
                    w_ram_cycle_next = 1'b0;
                    w_accept         = 1'b1;
                end else begin
                    w_state_next     = r_state;
                end
            end
            ST_WRITE_SP: begin
                if (r_ram_cycle) begin
                    w_state_next     = ST_WRITE_PC;
                    w_ram_cycle_next = 1'b0;
                end else begin
                    w_ram_cycle_next = 1'b1;
                end
            end
            ST_WRITE_PC: begin
                if (r_ram_cycle) begin
                    w_state_next     = ST_DONE;
                    w_ram_cycle_next = 1'b0;
                end else begin
                    w_ram_cycle_next = 1'b1;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_ram_cycle_next = 1'b0;
            end
        endcase
    end

    // Snapshot capture; CSP is stored pre-biased so the loader's +2 restores it.
    always_comb begin
        if (w_accept) begin
            w_sp_snap_next   = bus.i_stack_pointer;
            w_csp_snap_next  = bus.i_call_stack_pointer - CSP_FRAME_BIAS;
            w_pc_snap_next   = bus.i_program_counter;
            w_flag_snap_next = bus.i_alu_flags;
        end else begin
            w_sp_snap_next   = r_sp_snap;
            w_csp_snap_next  = r_csp_snap;
            w_pc_snap_next   = r_pc_snap;
            w_flag_snap_next = r_flag_snap;
        end
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the registered state they describe.
    always_comb begin
        w_address_next  = r_address;
        w_data_in_next  = r_data_in;
        w_rw_mode_next  = RAM_READ;
        w_busy_next     = 1'b0;
        w_finished_next = 1'b0;
        case (w_state_next)
            ST_WRITE_SP: begin
                w_address_next = ADDR_W0;
                w_data_in_next = pack_pointers(w_sp_snap_next, w_csp_snap_next);
                w_rw_mode_next = RAM_WRITE;
                w_busy_next    = 1'b1;
            end
            ST_WRITE_PC: begin
                w_address_next = ADDR_W1;
                w_data_in_next = pack_pc_flags(w_pc_snap_next, w_flag_snap_next);
                w_rw_mode_next = RAM_WRITE;
                w_busy_next    = 1'b1;
            end
            ST_DONE: begin
                w_finished_next = 1'b1;
            end
            ST_IDLE: begin
                w_finished_next = 1'b0;
            end
            default: begin
                w_finished_next = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ram_cycle <= 1'b0;
            r_sp_snap   <= 8'h00;
            r_csp_snap  <= 8'h00;
            r_pc_snap   <= 9'h000;
            r_flag_snap <= 4'h0;
            r_address   <= 8'h00;
            r_data_in   <= 16'h0000;
            r_rw_mode   <= RAM_READ;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ram_cycle <= w_ram_cycle_next;
            r_sp_snap   <= w_sp_snap_next;
            r_csp_snap  <= w_csp_snap_next;
            r_pc_snap   <= w_pc_snap_next;
            r_flag_snap <= w_flag_snap_next;
            r_address   <= w_address_next;
            r_data_in   <= w_data_in_next;
            r_rw_mode   <= w_rw_mode_next;
            r_busy      <= w_busy_next;
            r_finished  <= w_finished_next;
        end
    end

    assign bus.o_address  = r_address;
    assign bus.o_data_in  = r_data_in;
    assign bus.o_rw_mode  = r_rw_mode;
    assign bus.o_busy     = r_busy;
    assign bus.o_finished = r_finished;

endmodule
